// File: rtl/alu_operand_stage_pkg.sv
// ============================================================================
// Module      : alu_operand_stage_pkg
// Description : Shared widths, ALUOp encodings and the execute-register record
//               for the operand-fetch / writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_operand_stage_pkg;

    localparam int XLEN    = 64;
    localparam int NREGS   = 32;
    localparam int AW      = 5;
    localparam int ALUOP_W = 4;

    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t ALU_AND = 4'b0000;
    localparam aluop_t ALU_OR  = 4'b0001;
    localparam aluop_t ALU_ADD = 4'b0010;
    localparam aluop_t ALU_SUB = 4'b0110;
    localparam aluop_t ALU_NOR = 4'b1100;

    // One operation sitting in EX: the ALU operands plus what writeback needs.
    typedef struct packed {
        logic            valid;
        logic            we;
        logic [AW-1:0]   rd;
        aluop_t          op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } ex_reg_t;

    // True when the EX-stage operation will write a real register this cycle.
    function automatic logic ex_writes(input ex_reg_t ex);
        return ex.valid && ex.we && (ex.rd != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_operand_stage_regfile.sv
// ============================================================================
// Module      : regfile_2r1w
// Description : Register file with two read ports, one debug read port and one
//               synchronous write port; entry 0 always reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] dbg_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reads see the array before any write at this edge; index 0 forced to zero.
    assign rs1_data = (rs1_addr == '0) ? '0 : mem_q[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : mem_q[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand fetch, EX register and writeback stage that drives an
//               external 64-bit ALU, with EX-to-ID result forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic            in_we,
    input  logic [3:0]      in_aluop,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            ex_valid,
    output logic            zero_flag,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic            zero_q;
    logic            wb_valid_q;
    logic [AW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic [XLEN-1:0] w_rf_rs1;
    logic [XLEN-1:0] w_rf_rs2;
    logic            w_ex_wr;
    logic            w_fwd_a;
    logic            w_fwd_b;
    logic [XLEN-1:0] w_a_src;
    logic [XLEN-1:0] w_b_src;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs1_addr (in_rs1),
        .rs2_addr (in_rs2),
        .dbg_addr (dbg_addr),
        .rs1_data (w_rf_rs1),
        .rs2_data (w_rf_rs2),
        .dbg_data (dbg_data),
        .wr_en    (w_ex_wr),
        .wr_addr  (ex_q.rd),
        .wr_data  (alu_result)
    );

    // The result being written this edge is not yet in the array, so a
    // dependent ID-stage read must take it straight from the ALU.
    assign w_ex_wr = ex_writes(ex_q);
    assign w_fwd_a = w_ex_wr && (ex_q.rd == in_rs1);
    assign w_fwd_b = w_ex_wr && !in_use_imm && (ex_q.rd == in_rs2);

    assign w_a_src = w_fwd_a    ? alu_result :
                                  w_rf_rs1;
    assign w_b_src = in_use_imm ? in_imm     :
                     w_fwd_b    ? alu_result :
                                  w_rf_rs2;

    // Idle cycles keep operands and op so the ALU inputs stay quiet.
    always_comb begin
        ex_d       = ex_q;
        ex_d.valid = in_valid;
        if (in_valid) begin
            ex_d.we = in_we;
            ex_d.rd = in_rd;
            ex_d.op = in_aluop;
            ex_d.a  = w_a_src;
            ex_d.b  = w_b_src;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zero_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= ex_q.valid && ex_q.we;
            if (ex_q.valid) begin
                zero_q    <= alu_zero;
                wb_rd_q   <= ex_q.rd;
                wb_data_q <= alu_result;
            end
        end
    end

    assign alu_a     = ex_q.a;
    assign alu_b     = ex_q.b;
    assign alu_op    = ex_q.op;
    assign ex_valid  = ex_q.valid;
    assign zero_flag = zero_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Table-driven bench for alu_operand_stage with a behavioural
//               64-bit ALU and a writeback scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [AW-1:0]   in_rd;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;
    logic            in_we;
    logic [3:0]      in_aluop;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            ex_valid;
    logic            zero_flag;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    alu_operand_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_we      (in_we),
        .in_aluop   (in_aluop),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .ex_valid   (ex_valid),
        .zero_flag  (zero_flag),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Stand-in for the downstream 64-bit ALU.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [3:0]      op;
        logic [XLEN-1:0] exp_data;
        logic            exp_zero;
    } vec_t;

    typedef struct {
        int              due;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            zero;
    } sb_t;

    localparam int NVEC = 13;
    vec_t            tbl [NVEC];
    sb_t             sb [$];
    logic [XLEN-1:0] exp_rf [NREGS];
    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Advance one edge, then compare any writeback against the scoreboard.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("wb_latency", 64'(cyc), 64'(e.due));
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_data", wb_data, e.data);
                check("zero_flag", 64'(zero_flag), 64'(e.zero));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("wb_missing", 64'(wb_valid), 64'd1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        sb_t e;
        tbl[0]  = '{5'd0, 5'd0, 5'd1,  64'd14,    1'b1, ALU_ADD, 64'd14, 1'b0};
        tbl[1]  = '{5'd0, 5'd0, 5'd2,  64'd10,    1'b1, ALU_ADD, 64'd10, 1'b0};
        tbl[2]  = '{5'd1, 5'd2, 5'd3,  64'd0,     1'b0, ALU_AND, 64'd10, 1'b0};
        tbl[3]  = '{5'd1, 5'd2, 5'd4,  64'd0,     1'b0, ALU_OR,  64'd14, 1'b0};
        tbl[4]  = '{5'd1, 5'd2, 5'd5,  64'd0,     1'b0, ALU_ADD, 64'd24, 1'b0};
        tbl[5]  = '{5'd1, 5'd2, 5'd6,  64'd0,     1'b0, ALU_SUB, 64'd4,  1'b0};
        tbl[6]  = '{5'd1, 5'd2, 5'd7,  64'd0,     1'b0, ALU_NOR, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
        tbl[7]  = '{5'd1, 5'd2, 5'd8,  64'd0,     1'b0, ALU_SUB, 64'd4,  1'b0};
        tbl[8]  = '{5'd8, 5'd8, 5'd9,  64'd0,     1'b0, ALU_SUB, 64'd0,  1'b1};
        tbl[9]  = '{5'd0, 5'd0, 5'd0,  64'd5,     1'b1, ALU_ADD, 64'd5,  1'b0};
        tbl[10] = '{5'd0, 5'd0, 5'd10, 64'd0,     1'b1, ALU_ADD, 64'd0,  1'b1};
        tbl[11] = '{5'd1, 5'd0, 5'd12, 64'h100,   1'b1, ALU_OR,  64'h10E, 1'b0};
        // rs2 names the register in EX, but the immediate must win.
        tbl[12] = '{5'd1, 5'd12, 5'd13, 64'd3,    1'b1, ALU_ADD, 64'd17, 1'b0};

        for (int r = 0; r < NREGS; r++) exp_rf[r] = '0;

        reset_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_use_imm = 1'b0; in_we = 1'b0; in_aluop = '0; dbg_addr = '0;

        step();
        step();
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_zero_flag", 64'(zero_flag), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        for (int r = 0; r < NREGS; r++) begin
            dbg_addr = AW'(r);
            #1;
            check("rst_dbg", dbg_data, 64'd0);
        end
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            in_valid   = 1'b1;
            in_rs1     = tbl[i].rs1;
            in_rs2     = tbl[i].rs2;
            in_rd      = tbl[i].rd;
            in_imm     = tbl[i].imm;
            in_use_imm = tbl[i].use_imm;
            in_we      = 1'b1;
            in_aluop   = tbl[i].op;
            e.due  = cyc + 2;
            e.rd   = tbl[i].rd;
            e.data = tbl[i].exp_data;
            e.zero = tbl[i].exp_zero;
            sb.push_back(e);
            if (tbl[i].rd != '0) exp_rf[tbl[i].rd] = tbl[i].exp_data;
            step();
        end

        // First idle edge: EX empties but ALU inputs must hold the last op.
        in_valid = 1'b0;
        in_imm   = 64'hDEAD;
        in_rs1   = 5'd2;
        step();
        check("idle_ex_valid", 64'(ex_valid), 64'd0);
        check("idle_alu_a", alu_a, 64'd14);
        check("idle_alu_b", alu_b, 64'd3);
        check("idle_alu_op", 64'(alu_op), 64'(ALU_ADD));

        for (int k = 0; k < 6 && sb.size() != 0; k++) step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        step();
        check("wb_idle", 64'(wb_valid), 64'd0);

        for (int r = 0; r < NREGS; r++) begin
            dbg_addr = AW'(r);
            #1;
            check("rf_dbg", dbg_data, exp_rf[r]);
        end

        // Reset lands while ADD x11 is in EX: nothing may be written back.
        in_valid = 1'b1; in_rs1 = '0; in_rd = 5'd11; in_imm = 64'd7;
        in_use_imm = 1'b1; in_we = 1'b1; in_aluop = ALU_ADD;
        step();
        check("midop_ex_valid", 64'(ex_valid), 64'd1);
        reset_n = 1'b0;
        in_rd   = 5'd12;
        step();
        check("rstmid_ex_valid", 64'(ex_valid), 64'd0);
        check("rstmid_wb_valid", 64'(wb_valid), 64'd0);
        dbg_addr = 5'd11;
        #1;
        check("rstmid_x11", dbg_data, 64'd0);
        dbg_addr = 5'd1;
        #1;
        check("rstmid_x1", dbg_data, 64'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();
        check("postrst_wb_valid", 64'(wb_valid), 64'd0);
        dbg_addr = 5'd11;
        #1;
        check("postrst_x11", dbg_data, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
